serial_alu: RTL and testbench

Parametrised multi-cycle ALU that processes a WIDTH-bit operation DIGIT bits per clock. It uses a single reusable DIGIT-bit slice and a registered carry, trading latency for area. It sits between the datapath register file and the writeback mux, and accepts one operation at a time through a start/done handshake. Compared with the single-bit combinational slice, it adds width and digit-size generalisation, SLT and NOR modes, status flags and sequencing.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_digit.sv | 40 ++++
 rtl/serial_alu.sv | 194 +++++++++++++++++++
 tb/tb_serial_alu.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU: op codes, FSM states and
// the operand-inversion helper used by both the slice and the sequencer.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

    function automatic logic needs_invert(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-bit ALU slice: ripple adder with optional b inversion
// plus bitwise ops; exposes the carry into its top bit for overflow detection.
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_invert_b,
    input  logic             i_cin,
    input  logic [2:0]       i_op,
    output logic [DIGIT-1:0] o_res,
    output logic             o_cout,
    output logic             o_msb_cin
);

    // Ripple carry chain and per-op result selection.
    always_comb begin : p_slice
        logic [DIGIT-1:0] bx;
        logic [DIGIT:0]   c;
        bx    = i_invert_b ? ~i_b : i_b;
        c     = '0;
        c[0]  = i_cin;
        o_res = '0;
        for (int i = 0; i < DIGIT; i++) begin
            c[i+1] = (i_a[i] & bx[i]) | (c[i] & (i_a[i] ^ bx[i]));
        end
        o_cout    = c[DIGIT];
        o_msb_cin = c[DIGIT-1];
        case (i_op)
            OP_AND:                 o_res = i_a & i_b;
            OP_OR:                  o_res = i_a | i_b;
            OP_NOR:                 o_res = ~(i_a | i_b);
            OP_ADD, OP_SUB, OP_SLT: o_res = i_a ^ bx ^ c[DIGIT-1:0];
            default:                o_res = '0;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU: one shared DIGIT-bit slice iterated N = WIDTH/DIGIT times
// with a registered carry; start/done handshake, flags valid with done.
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_operation,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_alu: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_res_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_cy;
    logic             r_msb_cin;
    logic             r_ready;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;

    logic [DIGIT-1:0]       w_slice_res;
    logic                   w_slice_cout;
    logic                   w_slice_msb_cin;
    logic                   w_last;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0]       w_fin_res;
    logic                   w_fin_zero;
    logic                   w_fin_carry;
    logic                   w_fin_ovf;

    assign w_last = (r_cnt == CW'(N - 1));
    assign w_cat  = {w_slice_res, r_res_sh};

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .i_a        (r_a[DIGIT-1:0]),
        .i_b        (r_b[DIGIT-1:0]),
        .i_invert_b (needs_invert(r_op)),
        .i_cin      (r_cy),
        .i_op       (r_op),
        .o_res      (w_slice_res),
        .o_cout     (w_slice_cout),
        .o_msb_cin  (w_slice_msb_cin)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture and digit-serial datapath.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= 3'b000;
            r_res_sh  <= '0;
            r_cnt     <= '0;
            r_cy      <= 1'b0;
            r_msb_cin <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a   <= i_a;
                        r_b   <= i_b;
                        r_op  <= i_operation;
                        r_cnt <= '0;
                        r_cy  <= needs_invert(i_operation);
                    end
                end
                ST_RUN: begin
                    r_res_sh <= w_cat[WIDTH+DIGIT-1:DIGIT];
                    r_cy     <= w_slice_cout;
                    r_a      <= r_a >> DIGIT;
                    r_b      <= r_b >> DIGIT;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_msb_cin <= w_slice_msb_cin;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Final result and flag formation; r_cy holds the MSB carry-out here.
    always_comb begin
        w_fin_res   = r_res_sh;
        w_fin_carry = r_cy;
        w_fin_ovf   = r_msb_cin ^ r_cy;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_fin_res = r_res_sh;
            end
            OP_SLT: begin
                w_fin_res = WIDTH'(r_res_sh[WIDTH-1] ^ r_msb_cin ^ r_cy);
            end
            OP_AND, OP_OR, OP_NOR: begin
                w_fin_carry = 1'b0;
                w_fin_ovf   = 1'b0;
            end
            default: begin
                w_fin_res   = '0;
                w_fin_carry = 1'b0;
                w_fin_ovf   = 1'b0;
            end
        endcase
        w_fin_zero = (w_fin_res == '0);
    end

    // Registered outputs; result and flags only change in FINISH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == ST_IDLE);
            r_done  <= (r_state == ST_FINISH);
            if (r_state == ST_FINISH) begin
                r_result <= w_fin_res;
                r_zero   <= w_fin_zero;
                r_carry  <= w_fin_carry;
                r_ovf    <= w_fin_ovf;
            end
        end
    end

    assign o_ready    = r_ready;
    assign o_done     = r_done;
    assign o_result   = r_result;
    assign o_zero     = r_zero;
    assign o_carry    = r_carry;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: an 8-bit/1-bit-digit and a 32-bit/4-bit-digit
// instance driven by directed vectors; a negedge monitor checks every done.
module tb_serial_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, start32;
    logic [2:0]  op8, op32;
    logic [7:0]  a8, b8;
    logic [31:0] a32, b32;
    logic        ready8, done8, zero8, carry8, ovf8;
    logic [7:0]  result8;
    logic        ready32, done32, zero32, carry32, ovf32;
    logic [31:0] result32;

    serial_alu #(.WIDTH(8), .DIGIT(1)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_operation(op8),
        .i_a(a8), .i_b(b8), .o_ready(ready8), .o_done(done8), .o_result(result8),
        .o_zero(zero8), .o_carry(carry8), .o_overflow(ovf8)
    );

    serial_alu #(.WIDTH(32), .DIGIT(4)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start32), .i_operation(op32),
        .i_a(a32), .i_b(b32), .o_ready(ready32), .o_done(done32), .o_result(result32),
        .o_zero(zero32), .o_carry(carry32), .o_overflow(ovf32)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        int          due;
    } exp_t;

    exp_t q8[$];
    exp_t q32[$];
    exp_t e8, e32;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pops the oldest expectation, including its due cycle.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", {31'd0, done8}, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("result8",   {24'd0, result8}, e8.res);
                check("zero8",     {31'd0, zero8},  {31'd0, e8.z});
                check("carry8",    {31'd0, carry8}, {31'd0, e8.c});
                check("overflow8", {31'd0, ovf8},   {31'd0, e8.v});
                check("latency8",  cyc, e8.due);
                check("ready_with_done8", {31'd0, ready8}, 32'd1);
            end
        end
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                check("unexpected_done32", {31'd0, done32}, 32'd0);
            end else begin
                e32 = q32.pop_front();
                check("result32",   result32,         e32.res);
                check("zero32",     {31'd0, zero32},  {31'd0, e32.z});
                check("carry32",    {31'd0, carry32}, {31'd0, e32.c});
                check("overflow32", {31'd0, ovf32},   {31'd0, e32.v});
                check("latency32",  cyc, e32.due);
            end
        end
    end

    // Called at a negedge; accept happens on the next posedge, done 9 edges later.
    task automatic issue(input bit w32, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res,
                         input logic z, input logic c, input logic v);
        exp_t e;
        e.res = res; e.z = z; e.c = c; e.v = v;
        e.due = cyc + 1 + 9;
        if (w32) begin
            start32 = 1'b1; op32 = op; a32 = a; b32 = b;
            q32.push_back(e);
        end else begin
            start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    // Leaves the caller on the negedge where done is seen.
    task automatic wait_done(input bit w32, input string name);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = w32 ? done32 : done8;
        end
        if (!got) check({name, "_timeout"}, {31'd0, (w32 ? done32 : done8)}, 32'd1);
    endtask

    task automatic stray_start8(input string name);
        check(name, {31'd0, ready8}, 32'd0);
        start8 = 1'b1; op8 = OP_SUB; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk);
        #1;
        start8 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; op8 = 3'b000; a8 = 8'h00; b8 = 8'h00;
        start32 = 1'b0; op32 = 3'b000; a32 = 32'h0; b32 = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready8",  {31'd0, ready8},  32'd1);
        check("rst_done8",   {31'd0, done8},   32'd0);
        check("rst_result8", {24'd0, result8}, 32'd0);
        check("rst_flags8",  {29'd0, zero8, carry8, ovf8}, 32'd0);
        check("rst_ready32", {31'd0, ready32}, 32'd1);
        check("rst_result32", result32, 32'd0);

        // Back-to-back table: each op issued in the done cycle of the previous one.
        issue(1'b0, OP_ADD, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b0, 1'b1); wait_done(1'b0, "add");
        issue(1'b0, OP_SUB, 32'h05, 32'h05, 32'h00, 1'b1, 1'b1, 1'b0); wait_done(1'b0, "sub_eq");
        issue(1'b0, OP_SUB, 32'h00, 32'h01, 32'hFF, 1'b0, 1'b0, 1'b0); wait_done(1'b0, "sub_neg");
        issue(1'b0, OP_SLT, 32'h80, 32'h01, 32'h01, 1'b0, 1'b1, 1'b1); wait_done(1'b0, "slt_t");
        issue(1'b0, OP_SLT, 32'h01, 32'h80, 32'h00, 1'b1, 1'b0, 1'b1); wait_done(1'b0, "slt_f");
        issue(1'b0, OP_AND, 32'hCA, 32'h5C, 32'h48, 1'b0, 1'b0, 1'b0); wait_done(1'b0, "and");
        issue(1'b0, OP_OR,  32'hCA, 32'h5C, 32'hDE, 1'b0, 1'b0, 1'b0); wait_done(1'b0, "or");
        issue(1'b0, OP_NOR, 32'hCA, 32'h5C, 32'h21, 1'b0, 1'b0, 1'b0); wait_done(1'b0, "nor");
        issue(1'b0, 3'b110, 32'hCA, 32'h5C, 32'h00, 1'b1, 1'b0, 1'b0); wait_done(1'b0, "illegal8");

        // Starts during RUN (edges E+3 and E+8) must be ignored.
        issue(1'b0, OP_ADD, 32'h12, 32'h34, 32'h46, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        stray_start8("busy_ready_c3");
        repeat (5) @(negedge clk);
        stray_start8("busy_ready_c8");
        wait_done(1'b0, "ignored_start");

        // Reset mid-operation: outputs clear at once, no done for the lost op.
        issue(1'b0, OP_ADD, 32'h55, 32'h11, 32'h66, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        void'(q8.pop_back());
        #1;
        check("midrst_ready8",  {31'd0, ready8},  32'd1);
        check("midrst_done8",   {31'd0, done8},   32'd0);
        check("midrst_result8", {24'd0, result8}, 32'd0);
        check("midrst_flags8",  {29'd0, zero8, carry8, ovf8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(1'b0, OP_ADD, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1'b0); wait_done(1'b0, "after_rst");

        // 32-bit, 4-bit digits: still nine cycles.
        @(negedge clk);
        issue(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b1, 1'b1, 1'b0); wait_done(1'b1, "add32");
        issue(1'b1, 3'b111, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0, 1'b1, 1'b0, 1'b0); wait_done(1'b1, "illegal32");
        issue(1'b1, OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1); wait_done(1'b1, "sub32_ovf");

        repeat (3) @(negedge clk);
        check("drain8",  q8.size(),  32'd0);
        check("drain32", q32.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
